// File: rtl/adc_spi_pkg.sv
// Shared types and frame geometry for the MAX19777-style ADC SPI master.
// A 16-bit frame carries one leading zero, 12 data bits (MSB first),
// two trailing zeros and one high-Z bit.
package adc_spi_pkg;

    localparam int unsigned FRAME_BITS     = 16;
    localparam int unsigned SAMPLE_BITS    = 12;
    // Positions of the sample inside the 16-bit capture word. Captured bit k
    // (1..16) lands at word index FRAME_BITS-k.
    localparam int unsigned SAMPLE_MSB_POS = 14;
    localparam int unsigned SAMPLE_LSB_POS = 3;

    // Width of the SCLK half-period counter and the quiet-time counter (1..255).
    localparam int unsigned CNT_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_e;

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: CLK_DIV half-period counter plus the SCLK register.
// While run_i is low SCLK is parked high and the counter is held at zero, so
// the first tick after run_i rises is always a falling edge CLK_DIV cycles on.
module adc_sclk_gen
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic CLK,
    input  logic nRST,
    input  logic run_i,
    output logic rise_o,
    output logic fall_o,
    output logic sclk_o
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             sclk_q;
    logic             tick;

    assign tick   = run_i && (cnt_q == DIV_LAST);
    // Ticks are announced in the cycle before SCLK changes, so the FSM acts on
    // the same CLK edge that moves SCLK.
    assign rise_o = tick && !sclk_q;
    assign fall_o = tick &&  sclk_q;
    assign sclk_o = sclk_q;

    // Half-period counter and SCLK toggle; idle level is high.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else if (!run_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b1;
        end else if (tick) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/adc_spi_master.sv
// SPI master for a MAX19777-style 12-bit ADC (16-SCLK frame, nCS fall starts
// the conversion). Data is captured on the CLK edge that drives SCLK 0->1.
// Optional build macro ADC_FRAME_CHECK_EN: when defined, FRAME_ERR flags a
// frame whose leading bit or two trailing zero bits are nonzero; when
// undefined, FRAME_ERR is tied low and no check logic exists.
module adc_spi_master
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned QUIET_CYCLES = 2,
    parameter bit          CONTINUOUS   = 1'b0
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   START,
    input  logic                   DOUT,
    output logic                   nCS,
    output logic                   SCLK,
    output logic [SAMPLE_BITS-1:0] SAMPLE,
    output logic                   SAMPLE_VALID,
    output logic                   BUSY,
    output logic                   FRAME_ERR
);

    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    state_e                 state_q;
    logic                   ncs_q;
    logic [3:0]             bit_cnt_q;
    logic [CNT_W-1:0]       quiet_cnt_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [SAMPLE_BITS-1:0] sample_q;
    logic                   valid_q;

    logic                   sclk_run;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [FRAME_BITS-1:0]  frame_w;
    logic                   go;

    // SCLK only runs while nCS is low and the frame is in progress.
    assign sclk_run = (state_q == ST_SETUP) || (state_q == ST_SHIFT);
    // Shift register contents including the bit being captured this edge.
    assign frame_w  = (shift_q << 1) | FRAME_BITS'(DOUT);
    assign go       = START || CONTINUOUS;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .CLK    (CLK),
        .nRST   (nRST),
        .run_i  (sclk_run),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall),
        .sclk_o (SCLK)
    );

`ifdef ADC_FRAME_CHECK_EN
    logic frame_err_q;
    logic frame_bad;

    // Captured bits 1, 14 and 15 must read zero in a well-formed frame.
    assign frame_bad = frame_w[FRAME_BITS-1] | frame_w[FRAME_BITS-14] | frame_w[FRAME_BITS-15];
    assign FRAME_ERR = frame_err_q;
`else
    assign FRAME_ERR = 1'b0;
`endif

    // Frame sequencer: IDLE -> SETUP -> SHIFT (16 captures) -> QUIET.
    // NOTE: reset is asynchronous so nCS/SCLK return to idle immediately,
    // even mid-frame, without waiting for a clock edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_IDLE;
            ncs_q       <= 1'b1;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shift_q     <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
`ifdef ADC_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_SETUP;
                        ncs_q   <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    if (sclk_fall) begin
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (sclk_rise) begin
                        shift_q   <= frame_w;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            // Bit 16 is the ADC's high-Z bit: it only enters
                            // the shift register and never reaches an output.
                            sample_q    <= frame_w[SAMPLE_MSB_POS:SAMPLE_LSB_POS];
                            valid_q     <= 1'b1;
`ifdef ADC_FRAME_CHECK_EN
                            frame_err_q <= frame_bad;
`endif
                            ncs_q       <= 1'b1;
                            quiet_cnt_q <= '0;
                            state_q     <= ST_QUIET;
                        end
                    end
                end

                ST_QUIET: begin
                    if (quiet_cnt_q == QUIET_LAST) begin
                        quiet_cnt_q <= '0;
                        if (go) begin
                            state_q <= ST_SETUP;
                            ncs_q   <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        quiet_cnt_q <= quiet_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    ncs_q   <= 1'b1;
                end
            endcase
        end
    end

    assign nCS          = ncs_q;
    assign SAMPLE       = sample_q;
    assign SAMPLE_VALID = valid_q;
    assign BUSY         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_master.sv
// Directed bench for adc_spi_master. Three instances share one clock:
//   u0: CLK_DIV=1, QUIET_CYCLES=2, START-driven
//   u1: CLK_DIV=2, QUIET_CYCLES=2, CONTINUOUS=1, incrementing slave
//   u2: CLK_DIV=3, QUIET_CYCLES=2, START-driven
// A behavioural ADC slave per instance loads {0, sample, 000} at nCS fall and
// shifts one bit out after each SCLK fall.
module tb_adc_spi_master;

    logic        clk = 1'b0;
    logic [2:0]  nrst  = '0;
    logic [2:0]  start = '0;
    logic [2:0]  dout  = '0;

    logic        ncs0, ncs1, ncs2;
    logic        sclk0, sclk1, sclk2;
    logic        valid0, valid1, valid2;
    logic        busy0, busy1, busy2;
    logic        ferr0, ferr1, ferr2;
    logic [11:0] sample0, sample1, sample2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;

    // Slave model state.
    logic [11:0] sl_seed  [3];
    bit   [11:0] sl_ofs   [3];
    bit   [15:0] sl_sr    [3];
    bit          sl_inc   [3];
    bit          sl_force1[3];
    logic [2:0]  prev_ncs  = '1;
    logic [2:0]  prev_sclk = '1;

    wire  [2:0]  ncs_v  = {ncs2, ncs1, ncs0};
    wire  [2:0]  sclk_v = {sclk2, sclk1, sclk0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_master #(.CLK_DIV(1), .QUIET_CYCLES(2), .CONTINUOUS(1'b0)) u0 (
        .CLK(clk), .nRST(nrst[0]), .START(start[0]), .DOUT(dout[0]),
        .nCS(ncs0), .SCLK(sclk0), .SAMPLE(sample0), .SAMPLE_VALID(valid0),
        .BUSY(busy0), .FRAME_ERR(ferr0)
    );

    adc_spi_master #(.CLK_DIV(2), .QUIET_CYCLES(2), .CONTINUOUS(1'b1)) u1 (
        .CLK(clk), .nRST(nrst[1]), .START(start[1]), .DOUT(dout[1]),
        .nCS(ncs1), .SCLK(sclk1), .SAMPLE(sample1), .SAMPLE_VALID(valid1),
        .BUSY(busy1), .FRAME_ERR(ferr1)
    );

    adc_spi_master #(.CLK_DIV(3), .QUIET_CYCLES(2), .CONTINUOUS(1'b0)) u2 (
        .CLK(clk), .nRST(nrst[2]), .START(start[2]), .DOUT(dout[2]),
        .nCS(ncs2), .SCLK(sclk2), .SAMPLE(sample2), .SAMPLE_VALID(valid2),
        .BUSY(busy2), .FRAME_ERR(ferr2)
    );

    // ADC slave: reacts on the falling CLK edge, well away from the capture edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (prev_ncs[i] && !ncs_v[i])
                sl_sr[i] = {1'b0, sl_seed[i] + sl_ofs[i], 3'b000};
            if (!prev_ncs[i] && ncs_v[i] && sl_inc[i])
                sl_ofs[i] = sl_ofs[i] + 12'd1;
            if (prev_sclk[i] && !sclk_v[i] && !ncs_v[i]) begin
                dout[i]  = sl_force1[i] | sl_sr[i][15];
                sl_sr[i] = sl_sr[i] << 1;
            end
            prev_ncs[i]  = ncs_v[i];
            prev_sclk[i] = sclk_v[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One START-triggered frame on u0; valid must appear at edge 32 only.
    task automatic frame_u0(input string tag, input logic [11:0] exp_sample, input logic exp_ferr);
        int   first_n = -1;
        int   pulses  = 0;
        logic ferr_seen = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check({tag, "_ncs_low"}, 32'(ncs0), 32'd0);
        check({tag, "_busy"},    32'(busy0), 32'd1);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (valid0) begin
                pulses++;
                if (first_n < 0) first_n = n;
                ferr_seen = ferr0;
            end
        end
        check({tag, "_valid_edge"}, 32'(first_n), 32'd32);
        check({tag, "_pulses"},     32'(pulses),  32'd1);
        check({tag, "_sample"},     32'(sample0), 32'(exp_sample));
        check({tag, "_ferr"},       32'(ferr_seen), 32'(exp_ferr));
        check({tag, "_idle"},       32'(busy0),   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   valid_cnt;
        int   fall_cnt;
        logic p_ncs;
        int   v_cyc [3];
        logic [11:0] v_smp [3];
        int   got;
        int   first_n, low_runs, high_runs, bad_runs, len;
        logic prev_s, seen_low;
        logic exp_ferr_force;

        for (int i = 0; i < 3; i++) begin
            sl_seed[i]   = 12'h000;
            sl_inc[i]    = 1'b0;
            sl_force1[i] = 1'b0;
        end
`ifdef ADC_FRAME_CHECK_EN
        exp_ferr_force = 1'b1;
`else
        exp_ferr_force = 1'b0;
`endif

        // Reset state, including the continuous instance held in reset.
        repeat (3) @(negedge clk);
        check("rst_ncs",    32'(ncs0),    32'd1);
        check("rst_sclk",   32'(sclk0),   32'd1);
        check("rst_sample", 32'(sample0), 32'd0);
        check("rst_valid",  32'(valid0),  32'd0);
        check("rst_busy",   32'(busy0),   32'd0);
        check("rst_ferr",   32'(ferr0),   32'd0);
        check("rst_cont_ncs", 32'(ncs1),  32'd1);
        nrst[0] = 1'b1;
        nrst[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", 32'(ncs0), 32'd1);

        // Single frame, sample 12'h001.
        sl_seed[0] = 12'h001;
        frame_u0("f001", 12'h001, 1'b0);

        // START re-asserted during SHIFT is ignored: one frame only.
        sl_seed[0] = 12'h123;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        valid_cnt = 0;
        fall_cnt  = 0;
        p_ncs     = ncs0;
        for (int n = 1; n <= 80; n++) begin
            start[0] = (n >= 10 && n <= 14);
            @(negedge clk);
            if (valid0) valid_cnt++;
            if (p_ncs && !ncs0) fall_cnt++;
            p_ncs = ncs0;
        end
        start[0] = 1'b0;
        check("ign_valid_cnt", 32'(valid_cnt), 32'd1);
        check("ign_extra_frames", 32'(fall_cnt), 32'd0);
        check("ign_sample", 32'(sample0), 32'h123);

        // Reset at bit 7 (capture edge 14) of a frame.
        sl_seed[0] = 12'h5A5;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (13) @(negedge clk);
        nrst[0] = 1'b0;
        #1;
        check("mid_rst_ncs",    32'(ncs0),    32'd1);
        check("mid_rst_sclk",   32'(sclk0),   32'd1);
        check("mid_rst_sample", 32'(sample0), 32'd0);
        check("mid_rst_busy",   32'(busy0),   32'd0);
        valid_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (valid0) valid_cnt++;
        end
        nrst[0] = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (valid0) valid_cnt++;
        end
        check("mid_rst_no_valid", 32'(valid_cnt), 32'd0);
        frame_u0("after_rst", 12'h5A5, 1'b0);

        // DOUT forced high.
        sl_force1[0] = 1'b1;
        frame_u0("force1", 12'hFFF, exp_ferr_force);
        sl_force1[0] = 1'b0;

        // Continuous mode, CLK_DIV=2: samples 1,2,3 exactly 66 cycles apart.
        sl_seed[1] = 12'h001;
        sl_inc[1]  = 1'b1;
        @(negedge clk);
        nrst[1] = 1'b1;
        got = 0;
        for (int n = 0; n < 300 && got < 3; n++) begin
            @(negedge clk);
            if (valid1) begin
                v_cyc[got] = cyc;
                v_smp[got] = sample1;
                got++;
            end
        end
        check("cont_frames", 32'(got), 32'd3);
        if (got == 3) begin
            check("cont_s1", 32'(v_smp[0]), 32'd1);
            check("cont_s2", 32'(v_smp[1]), 32'd2);
            check("cont_s3", 32'(v_smp[2]), 32'd3);
            check("cont_gap12", 32'(v_cyc[1] - v_cyc[0]), 32'd66);
            check("cont_gap23", 32'(v_cyc[2] - v_cyc[1]), 32'd66);
        end
        nrst[1] = 1'b0;

        // CLK_DIV=3 frame, 12'hA5A, SCLK phases of exactly 3 cycles.
        sl_seed[2] = 12'hA5A;
        @(negedge clk);
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        first_n   = -1;
        low_runs  = 0;
        high_runs = 0;
        bad_runs  = 0;
        len       = 1;
        prev_s    = sclk2;
        seen_low  = 1'b0;
        for (int n = 1; n <= 110; n++) begin
            @(negedge clk);
            if (valid2 && first_n < 0) first_n = n;
            if (sclk2 == prev_s) begin
                len++;
            end else begin
                if (!prev_s) begin
                    low_runs++;
                    if (len != 3) bad_runs++;
                end else if (seen_low) begin
                    high_runs++;
                    if (len != 3) bad_runs++;
                end
                if (!sclk2) seen_low = 1'b1;
                len    = 1;
                prev_s = sclk2;
            end
        end
        check("div3_sample",     32'(sample2),   32'hA5A);
        check("div3_valid_edge", 32'(first_n),   32'd96);
        check("div3_low_runs",   32'(low_runs),  32'd16);
        check("div3_high_runs",  32'(high_runs), 32'd15);
        check("div3_bad_runs",   32'(bad_runs),  32'd0);
        check("div3_end_sclk",   32'(sclk2),     32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
